// File: rtl/multdiv_sequencer.sv
// Sequencer for the iterative multiply/divide unit: launch, wait with watchdog, single writeback.
// Define MULTDIV_SEQ_PERF_EN to add the perf_ops / perf_stall_cycles counters.
module multdiv_sequencer #(
  parameter int unsigned MAX_CYCLES   = 40,
  parameter int unsigned RSTATUS_REG  = 30,
  parameter int unsigned MUL_EXC_CODE = 4,
  parameter int unsigned DIV_EXC_CODE = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_mul,
  input  logic        start_div,
  input  logic        flush,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [4:0]  rd_in,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
`ifdef MULTDIV_SEQ_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_WB} state_e;

  localparam int unsigned    CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(MAX_CYCLES - 1);
  localparam logic [4:0]     STATUS_IDX = 5'(RSTATUS_REG);
  localparam logic [31:0]    MUL_EXC    = 32'(MUL_EXC_CODE);
  localparam logic [31:0]    DIV_EXC    = 32'(DIV_EXC_CODE);

  state_e        state_q;
  logic          op_div_q;
  logic [4:0]    rd_q;
  logic [31:0]   op_a_q, op_b_q;
  logic [CW-1:0] cnt_q;
  logic          mult_q, div_q, stall_q, busy_q;
  logic          wb_valid_q;
  logic [4:0]    wb_rd_q;
  logic [31:0]   wb_data_q;

  logic start_ok;
  logic wait_exc;

  assign start_ok = (start_mul | start_div) & ~flush;
  // A timeout leaves md_ready low, which by itself marks the result as an exception.
  assign wait_exc = ~md_ready | md_exception;

  // The IDLE term must be combinational so the issuing instruction is held in its own cycle.
  assign stall = stall_q | ((state_q == S_IDLE) & start_ok);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_div_q   <= 1'b0;
      rd_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      cnt_q      <= '0;
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      stall_q    <= 1'b0;
      busy_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values; the defaults
      // below are overridden later in the same block, giving one-cycle pulses without latches.
      mult_q     <= 1'b0;
      div_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q  <= S_LAUNCH;
            op_div_q <= ~start_mul;
            rd_q     <= rd_in;
            op_a_q   <= operand_a;
            op_b_q   <= operand_b;
            mult_q   <= start_mul;
            div_q    <= ~start_mul;
            stall_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_LAUNCH: begin
          cnt_q <= '0;
          if (flush) begin
            state_q <= S_IDLE;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            state_q <= S_IDLE;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (md_ready || cnt_q == CNT_LAST) begin
            state_q <= S_WB;
            stall_q <= 1'b0;
            if (wait_exc) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= STATUS_IDX;
              wb_data_q  <= op_div_q ? DIV_EXC : MUL_EXC;
            end else begin
              wb_valid_q <= (rd_q != 5'd0);
              wb_rd_q    <= rd_q;
              wb_data_q  <= md_result;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md_ctrl_mult = mult_q;
  assign md_ctrl_div  = div_q;
  assign md_operand_a = op_a_q;
  assign md_operand_b = op_b_q;
  assign busy         = busy_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;

`ifdef MULTDIV_SEQ_PERF_EN
  logic [31:0] perf_ops_q, perf_stall_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (state_q == S_WB) perf_ops_q <= perf_ops_q + 32'd1;
      if (stall)           perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ops          = perf_ops_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
